// File: rtl/longdiv_sequencer.sv
// rtl/longdiv_sequencer.sv - job FIFO and load/start sequencer in front of the longdivider block
// Optional abort of a stalled divide when DIV_TIMEOUT_EN is defined (adds res_to port).
module longdiv_sequencer #(
    parameter int N       = 8,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 32
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_q,
    output logic [N-1:0] res_r,
    output logic         res_dz,
`ifdef DIV_TIMEOUT_EN
    output logic         res_to,
`endif
    output logic         busy,
    output logic         LA,
    output logic         EB,
    output logic         s,
    output logic [N-1:0] DataA,
    output logic [N-1:0] DataB,
    input  logic         Done,
    input  logic [N-1:0] Q,
    input  logic [N-1:0] R
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT} state_t;
    state_t state, state_nxt;

    logic [N-1:0] mem_a [DEPTH];
    logic [N-1:0] mem_b [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          push, pop, empty;
    logic [N-1:0]  head_a, head_b;

    logic          res_ld;
    logic [N-1:0]  q_nxt, r_nxt;
    logic          dz_nxt;
`ifdef DIV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          to_nxt;
`endif

    assign push   = in_valid & in_ready;
    assign empty  = (count == '0);
    assign head_a = mem_a[rd_ptr];
    assign head_b = mem_b[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + {{AW{1'b0}}, 1'b1};
            2'b01:   count_nxt = count - {{AW{1'b0}}, 1'b1};
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // in_ready is registered from the next occupancy, so a full FIFO refuses even with a same-cycle pop
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            in_ready <= (count_nxt != (AW+1)'(DEPTH));
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        res_ld    = 1'b0;
        q_nxt     = '0;
        r_nxt     = '0;
        dz_nxt    = 1'b0;
`ifdef DIV_TIMEOUT_EN
        to_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_b == '0) begin
                        pop       = 1'b1;
                        res_ld    = 1'b1;
                        q_nxt     = '1;
                        r_nxt     = head_a;
                        dz_nxt    = 1'b1;
                        state_nxt = OUT;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD:  state_nxt = START;
            START: state_nxt = WAIT;
            WAIT: begin
                if (Done) begin
                    pop       = 1'b1;
                    res_ld    = 1'b1;
                    q_nxt     = Q;
                    r_nxt     = R;
                    state_nxt = OUT;
`ifdef DIV_TIMEOUT_EN
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    pop       = 1'b1;
                    res_ld    = 1'b1;
                    to_nxt    = 1'b1;
                    state_nxt = OUT;
`endif
                end
            end
            OUT: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state  <= IDLE;
            res_q  <= '0;
            res_r  <= '0;
            res_dz <= 1'b0;
            DataA  <= '0;
            DataB  <= '0;
        end else begin
            state <= state_nxt;
            if (res_ld) begin
                res_q  <= q_nxt;
                res_r  <= r_nxt;
                res_dz <= dz_nxt;
            end
            if (state == IDLE && state_nxt == LOAD) begin
                DataA <= head_a;
                DataB <= head_b;
            end
        end
    end

`ifdef DIV_TIMEOUT_EN
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            to_cnt <= '0;
            res_to <= 1'b0;
        end else begin
            if (state == START)     to_cnt <= '0;
            else if (state == WAIT) to_cnt <= to_cnt + 1'b1;
            if (res_ld) res_to <= to_nxt;
        end
    end
`endif

    assign LA        = (state == LOAD);
    assign EB        = (state == LOAD);
    assign s         = (state == START) || (state == WAIT);
    assign res_valid = (state == OUT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_longdiv_sequencer.sv
// tb/tb_longdiv_sequencer.sv - directed bench with a result-queue model and a behavioural divider stub
module tb_longdiv_sequencer;
    localparam int N = 8;

    logic         Clock = 1'b0;
    logic         Resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_q, res_r;
    logic         res_dz;
`ifdef DIV_TIMEOUT_EN
    logic         res_to;
`endif
    logic         busy, LA, EB, s;
    logic [N-1:0] DataA, DataB;
    logic         Done;
    logic [N-1:0] Q, R;

    longdiv_sequencer #(.N(N), .DEPTH(2), .TIMEOUT(32)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .res_r(res_r), .res_dz(res_dz),
`ifdef DIV_TIMEOUT_EN
        .res_to(res_to),
`endif
        .busy(busy), .LA(LA), .EB(EB), .s(s), .DataA(DataA), .DataB(DataB),
        .Done(Done), .Q(Q), .R(R)
    );

    always #5 Clock = ~Clock;

    // Divider stub: captures operands, raises Done lat cycles after s rises, never if hang
    logic [N-1:0] da, db;
    int           scnt;
    int           lat = 1;
    bit           hang = 1'b0;
    always @(posedge Clock) begin
        if (!Resetn) begin
            da <= '0; db <= '0; scnt <= 0; Done <= 1'b0;
        end else begin
            if (LA) da <= DataA;
            if (EB) db <= DataB;
            if (!s) begin
                scnt <= 0; Done <= 1'b0;
            end else begin
                scnt <= scnt + 1;
                Done <= !hang && (scnt + 1 >= lat);
            end
        end
    end
    assign Q = (db == 0) ? '1 : da / db;
    assign R = (db == 0) ? da : da % db;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         to;
    } res_t;
    res_t exp_q[$];
    res_t got[$];
    bit   next_to = 1'b0;
    bit   held = 1'b0;
    res_t prev;

    always @(negedge Clock) begin
        res_t e, a;
        if (!Resetn) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (next_to)        e = '{q: 0, r: 0, dz: 0, to: 1};
                else if (in_b == 0) e = '{q: 8'hFF, r: in_a, dz: 1, to: 0};
                else                e = '{q: in_a / in_b, r: in_a % in_b, dz: 0, to: 0};
                exp_q.push_back(e);
            end
            a.q = res_q; a.r = res_r; a.dz = res_dz; a.to = 1'b0;
`ifdef DIV_TIMEOUT_EN
            a.to = res_to;
`endif
            if (LA || EB) begin
                check("la_eb_pair", {31'd0, LA}, {31'd0, EB});
                check("s_low_in_load", {31'd0, s}, 32'd0);
            end
            if (res_valid && held) begin
                check("hold_q", a.q, prev.q);
                check("hold_r", a.r, prev.r);
                check("hold_dz", a.dz, prev.dz);
            end
            if (res_valid && res_ready) begin
                check("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("model_q", a.q, e.q);
                    check("model_r", a.r, e.r);
                    check("model_dz", a.dz, e.dz);
`ifdef DIV_TIMEOUT_EN
                    check("model_to", a.to, e.to);
`endif
                end
                got.push_back(a);
            end
            held = res_valid && !res_ready;
            prev = a;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input bit to);
        int n = 0;
        in_a = a; in_b = b; in_valid = 1'b1; next_to = to;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        check(name, {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_las", {29'd0, LA, EB, s}, 32'd0);
        check("rst_data", {16'd0, DataA, DataB}, 32'd0);
        check("rst_res", {15'd0, res_q, res_r, res_dz}, 32'd0);
        Resetn = 1'b1;
        tick();

        // 15/2 through the divider handshake
        res_ready = 1'b1;
        push(8'd15, 8'd2, 0);
        tick();
        check("t1_load", {30'd0, LA, EB}, 32'd3);
        check("t1_data", {16'd0, DataA, DataB}, 32'h0F02);
        tick();
        check("t1_start", {29'd0, LA, EB, s}, 32'd1);
        tick();
        check("t1_wait_s", {31'd0, s}, 32'd1);
        tick();
        check("t1_valid_lat", {31'd0, res_valid}, 32'd1);
        check("t1_q", res_q, 8'h07);
        check("t1_r", res_r, 8'h01);
        check("t1_dz", res_dz, 0);
        tick();
        check("t1_idle", {30'd0, busy, res_valid}, 32'd0);

        // latency 3 + D with D = 3
        lat = 3;
        push(8'd100, 8'd7, 0);
        wait_valid("lat_valid", n);
        check("lat_cycles", n, 6);
        tick();

        // divide by zero resolved locally
        push(8'd200, 8'd0, 0);
        check("dz_no_la", {29'd0, LA, EB, s}, 32'd0);
        tick();
        check("dz_valid", {31'd0, res_valid}, 32'd1);
        check("dz_no_la2", {29'd0, LA, EB, s}, 32'd0);
        check("dz_res", {15'd0, res_q, res_r, res_dz}, {15'd0, 8'hFF, 8'hC8, 1'b1});
        tick();

        // backpressure, FIFO full, ordered drain
        lat = 2;
        got.delete();
        res_ready = 1'b0;
        push(8'd100, 8'd7, 0);
        push(8'd255, 8'd16, 0);
        check("t3_full", {31'd0, in_ready}, 32'd0);
        push(8'd9, 8'd10, 0);
        wait_valid("t3_valid", n);
        check("t3_first_q", res_q, 8'd14);
        repeat (5) tick();
        check("t3_held_q", res_q, 8'd14);
        check("t3_held_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        check("t3_one_consumed", got.size(), 1);
        wait_valid("t3_valid2", n);
        check("t3_second_q", res_q, 8'd15);
        check("t3_still_one", got.size(), 1);
        res_ready = 1'b1;
        n = 0;
        while (got.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        check("t3_count", got.size(), 3);
        if (got.size() == 3) begin
            check("t3_res0", {got[0].q, got[0].r}, {8'd14, 8'd2});
            check("t3_res1", {got[1].q, got[1].r}, {8'd15, 8'd15});
            check("t3_res2", {got[2].q, got[2].r}, {8'd0, 8'd9});
        end
        tick();

        // reset during WAIT
        lat = 10;
        push(8'd15, 8'd2, 0);
        n = 0;
        while (!s && n < 20) begin
            tick();
            n++;
        end
        repeat (2) tick();
        Resetn = 1'b0;
        tick();
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        check("t5_ctl", {27'd0, busy, res_valid, LA, EB, s}, 32'd0);
        check("t5_data", {16'd0, DataA, DataB}, 32'd0);
        check("t5_res", {15'd0, res_q, res_r, res_dz}, 32'd0);
        Resetn = 1'b1;
        lat = 1;
        tick();
        check("t5_fifo_empty", {31'd0, busy}, 32'd0);
        push(8'd15, 8'd2, 0);
        wait_valid("t5_valid", n);
        check("t5_after", {res_q, res_r}, {8'd7, 8'd1});
        tick();

`ifdef DIV_TIMEOUT_EN
        // stalled divider aborted after TIMEOUT wait cycles; next job still issues
        hang = 1'b1;
        push(8'd1, 8'd1, 1);
        push(8'd6, 8'd3, 0);
        n = 0;
        while (!res_valid && n < 100) begin
            if (s) n++;
            tick();
        end
        hang = 1'b0;
        check("to_s_cycles", n, 33);
        check("to_res", {15'd0, res_q, res_r, res_to}, 32'd1);
        tick();
        wait_valid("to_next_valid", n);
        check("to_next", {15'd0, res_q, res_r, res_to}, {15'd0, 8'd2, 8'd0, 1'b0});
        tick();
`endif

        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/longdiv_sequencer.md
Name: longdiv_sequencer

Overview:
Upstream job sequencer for the `longdivider` block.
- Accepts numerator/denominator pairs over a valid/ready interface and buffers them in a small FIFO.
- Drives the divider's load/start handshake (`LA`, `EB`, `s`, `DataA`, `DataB`), waits for `Done`, and captures `Q`/`R`.
- Returns each result over a valid/ready interface in issue order.
- Divide-by-zero never reaches the divider; the sequencer resolves it locally.

Parameters:
- `N`, 8, operand/result width; must match the divider's width.
- `DEPTH`, 2, input FIFO entries; power of two, ≥ 2.
- `TIMEOUT`, 32, maximum `WAIT` cycles before abort; used only with `DIV_TIMEOUT_EN`.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Resetn` in 1: synchronous active-low reset, sampled on rising `Clock`; shared with the divider.
- `in_valid` in 1: job offered.
- `in_ready` out 1: FIFO can accept; equals !full, registered.
- `in_a` in N: numerator.
- `in_b` in N: denominator.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed.
- `res_q` out N: quotient.
- `res_r` out N: remainder.
- `res_dz` out 1: divide-by-zero flag for this result.
- `res_to` out 1: timeout flag; present only with `DIV_TIMEOUT_EN`.
- `busy` out 1: high in any state other than `IDLE`.
- `LA` out 1: divider load A.
- `EB` out 1: divider enable B.
- `s` out 1: divider start.
- `DataA` out N: divider numerator.
- `DataB` out N: divider denominator.
- `Done` in 1: divider complete, level signal.
- `Q` in N: divider quotient.
- `R` in N: divider remainder.

Behaviour:
- Reset (`Resetn` = 0 at an edge):
  - FIFO emptied; state `IDLE`.
  - All outputs 0 except `in_ready` = 1.
  - A reset mid-job discards the job and any unconsumed result; no partial result appears.
- FIFO:
  - Push when `in_valid` & `in_ready`; pop when a job completes.
  - Simultaneous push and pop is allowed when not full.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Head entry stays stable until popped.
- FSM states:
  - `IDLE`:
    - If FIFO non-empty and head `b` == 0: `res_q` = all ones, `res_r` = head `a`, `res_dz` = 1, pop, go to `OUT`. `LA`/`EB`/`s` stay 0.
    - If FIFO non-empty and head `b` != 0: go to `LOAD`.
  - `LOAD` (1 cycle): `LA` = `EB` = 1; `DataA`/`DataB` = head entry. Go to `START`.
  - `START` (1 cycle): `LA` = `EB` = 0; `s` = 1. Go to `WAIT`.
  - `WAIT`:
    - `s` held at 1.
    - On `Done` = 1: register `res_q` = `Q`, `res_r` = `R`, `res_dz` = 0, pop, go to `OUT`.
    - A `Done` sampled high in `START` is ignored.
  - `OUT`:
    - `s` = 0 and `res_valid` = 1.
    - `res_*` stay stable while `res_ready` = 0.
    - On `res_valid` & `res_ready`: clear `res_valid`, go to `IDLE`.
    - This guarantees `s` is low for ≥ 1 cycle between jobs.
- `DataA`/`DataB` hold their last loaded value outside `LOAD`.
- Latency:
  - Non-zero job, from the `IDLE` cycle with non-empty FIFO: `res_valid` rises 3 + D cycles later, where D is the number of `WAIT` cycles until `Done`.
  - Divide-by-zero: `res_valid` rises 1 cycle later.
- Throughput: one job in flight at the divider; the FIFO absorbs up to `DEPTH` queued jobs.
- Arithmetic: no computation for non-zero `b`; `res_q`/`res_r` are copied verbatim from the divider.

Optional Feature:
`DIV_TIMEOUT_EN`
- Defined:
  - Counter cleared on entry to `WAIT` and incremented each `WAIT` cycle.
  - If it reaches `TIMEOUT` without `Done`: `res_q` = `res_r` = 0, `res_to` = 1, pop, go to `OUT`.
  - `res_to` = 0 for normal and divide-by-zero results.
- Undefined: no counter and no `res_to` port; `WAIT` persists until `Done` or reset.

Test Plan:
1. Push 15/2, `res_ready` = 1 → `LA` = `EB` = 1 for one cycle with `DataA` = 0x0F, `DataB` = 0x02, then `s` high until `Done`. Result `res_q` = 0x07, `res_r` = 0x01, `res_dz` = 0.
2. Push 200/0 → `LA`/`EB`/`s` never assert. `res_valid` 1 cycle after `IDLE` detect, with `res_q` = 0xFF, `res_r` = 0xC8, `res_dz` = 1.
3. `res_ready` = 0; push 100/7, 255/16, 9/10 back-to-back → `in_ready` drops after the FIFO fills. Release `res_ready` → results in order: 14 r2, 15 r15, 0 r9; no job lost or duplicated.
4. `res_valid` held with `res_ready` = 0 for 5 cycles → `res_q`/`res_r`/`res_dz` stable. Single-cycle `res_ready` → exactly one result consumed.
5. `Resetn` = 0 for 1 cycle during `WAIT` → next cycle all outputs 0, `in_ready` = 1, FIFO empty. A following 15/2 job returns 7 r1.
6. With `DIV_TIMEOUT_EN` and a stub divider that never asserts `Done` → after 32 `WAIT` cycles, `res_valid` = 1 with `res_to` = 1, `res_q` = `res_r` = 0. The next queued job still issues.
